// File: rtl/pipeline_stage_buffer.sv
// Inter-stage pipeline register with a valid/ready handshake, an optional skid entry,
// flush with drop accounting, and saturating stall/drop counters.
module pipeline_stage_buffer #(
    parameter int unsigned DATA_W        = 96,
    parameter int unsigned SKID          = 1,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned ZERO_ON_FLUSH = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              FLUSH,
    input  logic              CNT_CLR,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [1:0]        OCCUPANCY,
    output logic [CNT_W-1:0]  STALL_CNT,
    output logic [CNT_W-1:0]  DROP_CNT
);

    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [1:0]        occ_q, occ_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              xfer_in, xfer_out;
    logic              stall_inc;
    logic [1:0]        drop_inc;
    logic [SUM_W-1:0]  stall_sum, drop_sum;

    // Skid build decouples IN_READY from OUT_READY; single-entry build allows same-cycle replace.
    always_comb begin
        IN_READY = 1'b0;
        if (RST_N && !FLUSH) begin
            if (SKID != 0) IN_READY = !skid_v_q;
            else           IN_READY = !main_v_q || OUT_READY;
        end
    end

    assign xfer_in  = IN_VALID && IN_READY;
    assign xfer_out = main_v_q && OUT_READY;

    always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (FLUSH) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            if (ZERO_ON_FLUSH != 0) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else if (SKID == 0) begin
            if (xfer_in) begin
                main_data_d = IN_DATA;
                main_v_d    = 1'b1;
            end else if (xfer_out) begin
                main_v_d = 1'b0;
            end
        end else begin
            // State is (main_valid, skid_valid); (0,1) cannot be reached.
            case ({main_v_q, skid_v_q})
                2'b00: begin
                    if (xfer_in) begin
                        main_data_d = IN_DATA;
                        main_v_d    = 1'b1;
                    end
                end
                2'b10: begin
                    if (xfer_in && xfer_out) begin
                        main_data_d = IN_DATA;
                    end else if (xfer_in) begin
                        skid_data_d = IN_DATA;
                        skid_v_d    = 1'b1;
                    end else if (xfer_out) begin
                        main_v_d = 1'b0;
                    end
                end
                2'b11: begin
                    if (xfer_out) begin
                        main_data_d = skid_data_q;
                        skid_v_d    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A beat leaving on the flush edge reached the consumer, so it is not a drop.
    always_comb begin
        occ_d     = 2'(main_v_d) + 2'(skid_v_d);
        stall_inc = main_v_q && !OUT_READY && !FLUSH;
        drop_inc  = 2'b00;
        if (FLUSH) drop_inc = 2'(main_v_q) + 2'(skid_v_q) - 2'(xfer_out);
        stall_sum = {2'b00, stall_q} + SUM_W'(stall_inc);
        drop_sum  = {2'b00, drop_q} + SUM_W'(drop_inc);
        stall_d   = (stall_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : stall_sum[CNT_W-1:0];
        drop_d    = (drop_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : drop_sum[CNT_W-1:0];
        if (CNT_CLR) begin
            stall_d = '0;
            drop_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            main_data_q <= '0;
            skid_data_q <= '0;
            occ_q       <= 2'b00;
            stall_q     <= '0;
            drop_q      <= '0;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            occ_q       <= occ_d;
            stall_q     <= stall_d;
            drop_q      <= drop_d;
        end
    end

    assign OUT_VALID = main_v_q;
    assign OUT_DATA  = main_data_q;
    assign OCCUPANCY = occ_q;
    assign STALL_CNT = stall_q;
    assign DROP_CNT  = drop_q;

endmodule
